// File: rtl/shot_controller.sv
`default_nettype none
// ============================================================================
// Module  : shot_controller
// Brief   : Single-shot sequencer for the duck-hunt pipeline: fire edge,
//           ammo, bullet flight, duck hit test, cooldown and bullet layer.
//           Optional muzzle flash: define SHOT_MUZZLE_FLASH_EN.
// Revision: 1.0 - initial release
// ============================================================================
module shot_controller #(
    parameter int          TICK_DIV       = 50000,
    parameter int          BULLET_STEP    = 4,
    parameter int          BULLET_W       = 4,
    parameter int          BULLET_H       = 8,
    parameter int          MUZZLE_Y       = 434,
    parameter int          BARREL_DX      = 29,
    parameter int          DUCK_W         = 32,
    parameter int          DUCK_H         = 32,
    parameter int          AMMO_MAX       = 3,
    parameter int          COOLDOWN_TICKS = 20,
    parameter int          FLASH_TICKS    = 3,
    parameter logic [5:0]  BULLET_COLOR   = 6'h3F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        fire,
    input  logic        reload,
    input  logic [9:0]  gun_x,
    input  logic [9:0]  duck_x,
    input  logic [9:0]  duck_y,
    input  logic        duck_alive,
    output logic        draw,
    output logic [5:0]  data,
    output logic        hit,
    output logic        miss,
    output logic [2:0]  ammo,
    output logic        busy
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_CD_W   = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_CD_W-1:0]   c_CD_LAST   = c_CD_W'(COOLDOWN_TICKS - 1);
    localparam logic [2:0]          c_AMMO_MAX  = 3'(AMMO_MAX);
    localparam logic [9:0]          c_LAUNCH_Y  = 10'(MUZZLE_Y - BULLET_H);
    localparam logic [9:0]          c_BARREL_DX = 10'(BARREL_DX);
    localparam logic [9:0]          c_STEP10    = 10'(BULLET_STEP);
    localparam logic [10:0]         c_STEP      = 11'(BULLET_STEP);
    localparam logic [10:0]         c_BW        = 11'(BULLET_W);
    localparam logic [10:0]         c_BH        = 11'(BULLET_H);
    localparam logic [10:0]         c_DW        = 11'(DUCK_W);
    localparam logic [10:0]         c_DH        = 11'(DUCK_H);

    if (AMMO_MAX < 1 || AMMO_MAX > 7 || TICK_DIV < 1 || COOLDOWN_TICKS < 1 ||
        FLASH_TICKS < 1) begin : g_param_check
        $error("shot_controller: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FIRE     = 3'd1,
        S_TRAVEL   = 3'd2,
        S_RESULT   = 3'd3,
        S_COOLDOWN = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_TICK_W-1:0]   r_tick_cnt;
    logic [c_CD_W-1:0]     r_cd_cnt;
    logic                  r_fire_sync;
    logic                  r_fire_q;
    logic [2:0]            r_ammo;
    logic [9:0]            r_bx;
    logic [9:0]            r_by;
    logic                  r_hit_flag;
    logic                  r_draw;
    logic [5:0]            r_data;

    logic                  w_tick;
    logic                  w_fire_rise;
    logic                  w_launch;
    logic                  w_reload;
    logic                  w_step;
    logic                  w_decide;
    logic                  w_decide_hit;
    logic                  w_overlap;
    logic                  w_bullet_px;
    logic                  w_pix;
    logic [10:0]           w_bx11;
    logic [10:0]           w_by11;
    logic [10:0]           w_dx11;
    logic [10:0]           w_dy11;
    logic [10:0]           w_hc11;
    logic [10:0]           w_vc11;

    assign w_tick      = (r_tick_cnt == c_TICK_LAST);
    // fire is asynchronous to the frame, so it passes one sync stage first
    assign w_fire_rise = r_fire_sync & ~r_fire_q;

    assign w_bx11 = {1'b0, r_bx};
    assign w_by11 = {1'b0, r_by};
    assign w_dx11 = {1'b0, duck_x};
    assign w_dy11 = {1'b0, duck_y};
    assign w_hc11 = {1'b0, hcount};
    assign w_vc11 = {1'b0, vcount};

    assign w_overlap = (w_bx11 < w_dx11 + c_DW) && (w_dx11 < w_bx11 + c_BW) &&
                       (w_by11 < w_dy11 + c_DH) && (w_dy11 < w_by11 + c_BH);

    assign w_bullet_px = (r_state == S_TRAVEL) &&
                         (w_hc11 >= w_bx11) && (w_hc11 < w_bx11 + c_BW) &&
                         (w_vc11 >= w_by11) && (w_vc11 < w_by11 + c_BH);

`ifdef SHOT_MUZZLE_FLASH_EN
    localparam int c_FL_W = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam logic [c_FL_W-1:0] c_FL_LAST = c_FL_W'(FLASH_TICKS - 1);
    localparam logic [10:0]       c_FLASH_Y0 = 11'(MUZZLE_Y - 6);
    localparam logic [10:0]       c_FLASH_Y1 = 11'(MUZZLE_Y - 1);

    logic [c_FL_W-1:0] r_flash_cnt;
    logic [10:0]       w_gx11;
    logic              w_flash_px;

    assign w_gx11     = {1'b0, gun_x};
    assign w_flash_px = (r_state == S_FIRE) &&
                        (w_hc11 >= w_gx11 + 11'd24) && (w_hc11 <= w_gx11 + 11'd38) &&
                        (w_vc11 >= c_FLASH_Y0) && (w_vc11 <= c_FLASH_Y1);
    assign w_pix      = w_bullet_px | w_flash_px;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flash_cnt <= '0;
        end else if (w_launch) begin
            r_flash_cnt <= '0;
        end else if (r_state == S_FIRE && w_tick) begin
            r_flash_cnt <= r_flash_cnt + 1'b1;
        end
    end
`else
    assign w_pix = w_bullet_px;
`endif

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_reload     = 1'b0;
        w_step       = 1'b0;
        w_decide     = 1'b0;
        w_decide_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reload) begin
                    w_reload = 1'b1;
                end else if (w_fire_rise && r_ammo != 3'd0) begin
                    w_launch     = 1'b1;
                    w_state_next = S_FIRE;
                end
            end
            S_FIRE: begin
`ifdef SHOT_MUZZLE_FLASH_EN
                if (w_tick && r_flash_cnt == c_FL_LAST) begin
                    w_state_next = S_TRAVEL;
                end
`else
                w_state_next = S_TRAVEL;
`endif
            end
            S_TRAVEL: begin
                if (w_tick) begin
                    if (w_overlap && duck_alive) begin
                        w_decide     = 1'b1;
                        w_decide_hit = 1'b1;
                        w_state_next = S_RESULT;
                    end else if (w_by11 < c_STEP) begin
                        w_decide     = 1'b1;
                        w_state_next = S_RESULT;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            S_RESULT: begin
                w_state_next = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (w_tick && r_cd_cnt == c_CD_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Tick counter restarts in RESULT so the cooldown spans whole ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (r_state == S_RESULT || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fire_sync <= 1'b0;
            r_fire_q    <= 1'b0;
            r_ammo      <= c_AMMO_MAX;
            r_bx        <= '0;
            r_by        <= '0;
            r_hit_flag  <= 1'b0;
            r_cd_cnt    <= '0;
            r_draw      <= 1'b0;
            r_data      <= '0;
        end else begin
            r_fire_sync <= fire;
            r_fire_q    <= r_fire_sync;
            if (w_reload) begin
                r_ammo <= c_AMMO_MAX;
            end else if (w_launch) begin
                r_ammo <= r_ammo - 3'd1;
            end
            if (w_launch) begin
                r_bx <= gun_x + c_BARREL_DX;
                r_by <= c_LAUNCH_Y;
            end else if (w_step) begin
                r_by <= r_by - c_STEP10;
            end
            if (w_decide) begin
                r_hit_flag <= w_decide_hit;
            end
            if (r_state == S_RESULT) begin
                r_cd_cnt <= '0;
            end else if (r_state == S_COOLDOWN && w_tick) begin
                r_cd_cnt <= r_cd_cnt + 1'b1;
            end
            r_draw <= w_pix;
            r_data <= w_pix ? BULLET_COLOR : 6'd0;
        end
    end

    assign draw = r_draw;
    assign data = r_data;
    assign hit  = (r_state == S_RESULT) &  r_hit_flag;
    assign miss = (r_state == S_RESULT) & ~r_hit_flag;
    assign ammo = r_ammo;
    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shot_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_shot_controller
// Brief   : Directed self-checking bench for shot_controller (TICK_DIV=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_shot_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        fire;
    logic        reload;
    logic [9:0]  gun_x;
    logic [9:0]  duck_x;
    logic [9:0]  duck_y;
    logic        duck_alive;
    logic        draw;
    logic [5:0]  data;
    logic        hit;
    logic        miss;
    logic [2:0]  ammo;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    shot_controller #(
        .TICK_DIV (4)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .hcount     (hcount),
        .vcount     (vcount),
        .fire       (fire),
        .reload     (reload),
        .gun_x      (gun_x),
        .duck_x     (duck_x),
        .duck_y     (duck_y),
        .duck_alive (duck_alive),
        .draw       (draw),
        .data       (data),
        .hit        (hit),
        .miss       (miss),
        .ammo       (ammo),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; inputs are driven and outputs sampled 1 ns later
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       pick = draw;
            1:       pick = hit;
            2:       pick = miss;
            default: pick = busy;
        endcase
    endfunction

    // Wait (bounded) until output sel equals val; optionally flag any pulse on forbid
    task automatic wait_for(input string tag, input int sel, input logic val,
                            input int bound, input int forbid);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (pick(sel) === val) break;
            if (forbid >= 0 && pick(forbid) === 1'b1) seen = 1'b1;
            step(1);
        end
        check(tag, 32'(pick(sel)), 32'(val));
        if (forbid >= 0) check({tag, "_no_other_pulse"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic seen;
        reset      = 1'b1;
        fire       = 1'b0;
        reload     = 1'b0;
        hcount     = 10'd0;
        vcount     = 10'd0;
        gun_x      = 10'd100;
        duck_x     = 10'd120;
        duck_y     = 10'd380;
        duck_alive = 1'b1;
        step(3);
        check("rst_ammo", 32'(ammo), 32'd3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_draw", 32'(draw), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_hit",  32'(hit),  32'd0);
        check("rst_miss", 32'(miss), 32'd0);
        reset = 1'b0;
        step(2);

        // Shot 1: duck alive at (120,380); bullet launched at (129,426)
        hcount = 10'd129;
        vcount = 10'd433;
        fire   = 1'b1;
        step(2);
        check("fire_busy", 32'(busy), 32'd1);
        check("fire_ammo", 32'(ammo), 32'd2);
        wait_for("launch_px", 0, 1'b1, 8, -1);
        check("launch_data", 32'(data), 32'h3F);
        fire   = 1'b0;
        hcount = 10'd133;
        step(1);
        check("right_edge_draw", 32'(draw), 32'd0);
        check("right_edge_data", 32'(data), 32'd0);
        hcount = 10'd129;
        vcount = 10'd410;
        wait_for("bullet_at_410", 0, 1'b1, 40, 1);
        wait_for("hit_pulse", 1, 1'b1, 10, 2);
        step(1);
        check("hit_width", 32'(hit), 32'd0);
        step(4);
        fire = 1'b1;
        step(75);
        check("cooldown_busy", 32'(busy), 32'd1);
        check("cooldown_nodraw", 32'(draw), 32'd0);
        step(1);
        check("cooldown_done", 32'(busy), 32'd0);
        step(4);
        check("no_queued_fire", 32'(busy), 32'd0);
        check("no_queued_ammo", 32'(ammo), 32'd2);
        fire = 1'b0;
        step(2);

        // Shot 2: duck not alive -> bullet climbs to by=2, then miss
        duck_alive = 1'b0;
        vcount     = 10'd2;
        fire       = 1'b1;
        step(3);
        check("shot2_ammo", 32'(ammo), 32'd1);
        fire = 1'b0;
        wait_for("bullet_at_top", 0, 1'b1, 600, 2);
        wait_for("miss_pulse", 2, 1'b1, 10, 1);
        step(1);
        check("miss_width", 32'(miss), 32'd0);
        wait_for("shot2_idle", 3, 1'b0, 200, -1);

        // Shot 3 empties the magazine, shot 4 must be ignored
        fire = 1'b1;
        step(3);
        check("shot3_ammo", 32'(ammo), 32'd0);
        fire = 1'b0;
        wait_for("shot3_idle", 3, 1'b0, 1000, -1);
        step(2);
        fire = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (busy) seen = 1'b1;
        end
        check("empty_fire_busy", 32'(seen), 32'd0);
        check("empty_fire_ammo", 32'(ammo), 32'd0);
        fire = 1'b0;
        step(3);

        // Reload coincident with a fire rise wins and discards the fire
        fire   = 1'b1;
        reload = 1'b1;
        step(3);
        reload = 1'b0;
        step(4);
        check("reload_busy", 32'(busy), 32'd0);
        check("reload_ammo", 32'(ammo), 32'd3);
        fire = 1'b0;
        step(3);

        // Reset in the middle of TRAVEL drops the bullet silently
        hcount = 10'd129;
        vcount = 10'd433;
        fire   = 1'b1;
        wait_for("travel_before_reset", 0, 1'b1, 10, -1);
        reset = 1'b1;
        fire  = 1'b0;
        step(1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ammo", 32'(ammo), 32'd3);
        check("midrst_draw", 32'(draw), 32'd0);
        check("midrst_hit",  32'(hit),  32'd0);
        check("midrst_miss", 32'(miss), 32'd0);
        reset = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (hit || miss || busy) seen = 1'b1;
        end
        check("midrst_quiet", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
